univ_shift_reg: RTL and testbench

UNIV_SHIFT_REG -- requirements
Module: univ_shift_reg

---
 rtl/usr_pkg.sv | 36 +++
 rtl/usr_step.sv | 59 +++++
 rtl/univ_shift_reg.sv | 135 +++++++++++++
 tb/tb_univ_shift_reg.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/usr_pkg.sv
// ---------------------------------------------------------------------------
// usr_pkg
// Shared definitions for the universal shift register slice.
//   mode_e  : operation select encodings carried on the 3-bit mode input
//   state_e : control FSM states (IDLE -> SHIFT -> DONE -> IDLE)
//   isShiftMode() : true for the five modes that step the register bit by bit
// ---------------------------------------------------------------------------
package usr_pkg;

    localparam int MODE_W = 3;

    typedef enum logic [MODE_W-1:0] {
        MODE_HOLD = 3'b000,
        MODE_LOAD = 3'b001,
        MODE_SHL  = 3'b010,
        MODE_SHR  = 3'b011,
        MODE_SAR  = 3'b100,
        MODE_ROL  = 3'b101,
        MODE_ROR  = 3'b110,
        MODE_CLR  = 3'b111
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    // Shift and rotate modes are the only ones that spend cycles in SHIFT;
    // HOLD, LOAD and CLR always complete at the accepting edge.
    function automatic logic isShiftMode(input mode_e m);
        return (m == MODE_SHL) || (m == MODE_SHR) || (m == MODE_SAR) ||
               (m == MODE_ROL) || (m == MODE_ROR);
    endfunction

endpackage

// File: rtl/usr_step.sv
// ---------------------------------------------------------------------------
// usr_step
// Purely combinational single 1-bit step of the shift register.
// Ports:
//   data_i  [WIDTH-1:0] : current register contents
//   mode_i  [2:0]       : latched operation (mode_e encoding)
//   sin_i               : serial input bit, used by SHL and SHR only
//   data_o  [WIDTH-1:0] : register contents after one step
//   sout_o              : bit pushed out across the boundary by this step
// Non-shift modes pass the data through and report sout_o = 0; the parent
// only consumes these outputs while it is stepping a shift/rotate mode.
// ---------------------------------------------------------------------------
module usr_step
    import usr_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] data_i,
    input  logic [2:0]       mode_i,
    input  logic             sin_i,
    output logic [WIDTH-1:0] data_o,
    output logic             sout_o
);

    // One step of the selected shift or rotate. SAR replicates the sign bit,
    // rotates feed the escaping bit back in at the other end and also report
    // it on sout_o, so sin_i is ignored for SAR/ROL/ROR.
    always_comb begin
        data_o = data_i;
        sout_o = 1'b0;
        case (mode_e'(mode_i))
            MODE_SHL: begin
                data_o = {data_i[WIDTH-2:0], sin_i};
                sout_o = data_i[WIDTH-1];
            end
            MODE_SHR: begin
                data_o = {sin_i, data_i[WIDTH-1:1]};
                sout_o = data_i[0];
            end
            MODE_SAR: begin
                data_o = {data_i[WIDTH-1], data_i[WIDTH-1:1]};
                sout_o = data_i[0];
            end
            MODE_ROL: begin
                data_o = {data_i[WIDTH-2:0], data_i[WIDTH-1]};
                sout_o = data_i[WIDTH-1];
            end
            MODE_ROR: begin
                data_o = {data_i[0], data_i[WIDTH-1:1]};
                sout_o = data_i[0];
            end
            default: begin
                data_o = data_i;
                sout_o = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/univ_shift_reg.sv
// ---------------------------------------------------------------------------
// univ_shift_reg
// Universal shift register with a small IDLE/SHIFT/DONE control FSM.
// One operation is accepted per start pulse while idle; multi-bit shifts and
// rotates are carried out one bit per clock.
// Ports:
//   clk                 : sole clock, rising edge
//   reset               : asynchronous active-high reset
//   d      [WIDTH-1:0]  : parallel load data
//   mode   [2:0]        : operation select (usr_pkg::mode_e), sampled with start
//   amount [AMT_W-1:0]  : number of 1-bit steps, sampled with start
//   start               : operation request, honoured only in IDLE
//   sin                 : serial input, sampled on every shift step
//   q      [WIDTH-1:0]  : register contents
//   q1     [WIDTH-1:0]  : bitwise complement of q
//   sout                : last bit shifted out (registered)
//   busy                : high whenever the FSM is not IDLE
//   done                : one-cycle completion pulse, q already final
// ---------------------------------------------------------------------------
module univ_shift_reg
    import usr_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int AMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    input  logic [2:0]       mode,
    input  logic [AMT_W-1:0] amount,
    input  logic             start,
    input  logic             sin,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q1,
    output logic             sout,
    output logic             busy,
    output logic             done
);

    state_e           state_q;
    mode_e            mode_q;
    logic [AMT_W-1:0] count_q;
    logic [WIDTH-1:0] data_q;
    logic             sout_q;
    logic             busy_q;
    logic             done_q;

    mode_e            startMode;
    logic [WIDTH-1:0] data_d;
    logic             sout_d;

    assign startMode = mode_e'(mode);

    // The step network always looks at the latched mode, never the live
    // mode input, so changes on mode during SHIFT have no effect.
    usr_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .data_i (data_q),
        .mode_i (mode_q),
        .sin_i  (sin),
        .data_o (data_d),
        .sout_o (sout_d)
    );

    // Control FSM and datapath registers in one block. busy and done are
    // registered alongside the state so they change exactly with it.
    // HOLD, LOAD, CLR and zero-length shifts go straight to DONE; real
    // shifts latch mode and count and then take one step per edge, the edge
    // that consumes the last count moving to DONE. start is only looked at
    // in IDLE, so a request during SHIFT or DONE is simply dropped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            mode_q  <= MODE_HOLD;
            count_q <= '0;
            data_q  <= '0;
            sout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    if (start) begin
                        busy_q <= 1'b1;
                        if (startMode == MODE_LOAD) begin
                            data_q  <= d;
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end else if (startMode == MODE_CLR) begin
                            data_q  <= '0;
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end else if (isShiftMode(startMode) && (amount != '0)) begin
                            mode_q  <= startMode;
                            count_q <= amount;
                            state_q <= ST_SHIFT;
                        end else begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                ST_SHIFT: begin
                    data_q  <= data_d;
                    sout_q  <= sout_d;
                    count_q <= count_q - AMT_W'(1);
                    if (count_q == AMT_W'(1)) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign q    = data_q;
    assign q1   = ~data_q;
    assign sout = sout_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_univ_shift_reg.sv
// ---------------------------------------------------------------------------
// tb_univ_shift_reg
// Self-checking bench for univ_shift_reg at WIDTH=8. A behavioural model
// tracks the register value and sout with plain integer arithmetic; every
// output is checked at the falling edge, away from the active clock edge.
// ---------------------------------------------------------------------------
module tb_univ_shift_reg;

    localparam int WIDTH = 8;
    localparam int AMT_W = 3;

    localparam int M_HOLD = 0;
    localparam int M_LOAD = 1;
    localparam int M_SHL  = 2;
    localparam int M_SHR  = 3;
    localparam int M_SAR  = 4;
    localparam int M_ROL  = 5;
    localparam int M_ROR  = 6;
    localparam int M_CLR  = 7;

    logic             clk = 1'b0;
    logic             reset;
    logic [WIDTH-1:0] d;
    logic [2:0]       mode;
    logic [AMT_W-1:0] amount;
    logic             start;
    logic             sin;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] q1;
    logic             sout;
    logic             busy;
    logic             done;

    int checks   = 0;
    int failures = 0;
    int modelQ   = 0;
    int modelSout = 0;

    always #5 clk = ~clk;

    univ_shift_reg #(
        .WIDTH (WIDTH),
        .AMT_W (AMT_W)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .d      (d),
        .mode   (mode),
        .amount (amount),
        .start  (start),
        .sin    (sin),
        .q      (q),
        .q1     (q1),
        .sout   (sout),
        .busy   (busy),
        .done   (done)
    );

    // Runaway guard: a stuck simulation still reports and ends.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic checkAll(input string tag, input int expBusy, input int expDone);
        checkOutput({tag, "_q"},    32'(q),    32'(modelQ & 255));
        checkOutput({tag, "_q1"},   32'(q1),   32'((~modelQ) & 255));
        checkOutput({tag, "_sout"}, 32'(sout), 32'(modelSout));
        checkOutput({tag, "_busy"}, 32'(busy), 32'(expBusy));
        checkOutput({tag, "_done"}, 32'(done), 32'(expDone));
    endtask

    // Reference semantics of one bit step, as integer arithmetic on an 8-bit value.
    function automatic void stepModel(input int m, input int s);
        int v;
        v = modelQ & 255;
        case (m)
            M_SHL: begin modelSout = (v >> 7) & 1; modelQ = ((v << 1) | s) & 255; end
            M_SHR: begin modelSout = v & 1; modelQ = (v >> 1) | (s << 7); end
            M_SAR: begin modelSout = v & 1; modelQ = (v >> 1) | (v & 128); end
            M_ROL: begin modelSout = (v >> 7) & 1; modelQ = ((v << 1) | (v >> 7)) & 255; end
            M_ROR: begin modelSout = v & 1; modelQ = (v >> 1) | ((v & 1) << 7); end
            default: modelQ = v;
        endcase
    endfunction

    // Issue one operation starting in the current low clock phase with the
    // DUT idle, follow it to completion and back to idle.
    // sinMode < 0 gives random serial input per step, otherwise a constant.
    // midStart fires extra CLR requests during SHIFT and DONE that must be dropped.
    task automatic applyStimulus(input int m, input int k, input int dVal,
                                 input int sinMode, input bit midStart);
        int sinBit;
        mode   = 3'(m);
        amount = AMT_W'(k);
        d      = 8'(dVal);
        start  = 1'b1;
        sin    = 1'($urandom_range(0, 1));
        @(negedge clk);
        start  = 1'b0;
        mode   = 3'($urandom);
        amount = AMT_W'($urandom);
        d      = 8'($urandom);
        if (m >= M_SHL && m <= M_ROR && k > 0) begin
            for (int i = 1; i <= k; i++) begin
                checkAll("shift", 1, 0);
                sinBit = (sinMode < 0) ? int'($urandom_range(0, 1)) : sinMode;
                sin = 1'(sinBit);
                if (midStart && i == 2) begin
                    start = 1'b1;
                    mode  = 3'(M_CLR);
                end else begin
                    start = 1'b0;
                end
                stepModel(m, sinBit);
                @(negedge clk);
            end
            start = 1'b0;
        end else if (m == M_LOAD) begin
            modelQ = dVal & 255;
        end else if (m == M_CLR) begin
            modelQ = 0;
        end
        checkAll("done", 1, 1);
        if (midStart) begin
            start = 1'b1;
            mode  = 3'(M_CLR);
        end
        @(negedge clk);
        start = 1'b0;
        checkAll("idle", 0, 0);
    endtask

    initial begin
        int sinBit;
        reset  = 1'b1;
        d      = '0;
        mode   = '0;
        amount = '0;
        start  = 1'b0;
        sin    = 1'b0;

        // Reset state, before and across a clock edge.
        #2;
        checkAll("reset", 0, 0);
        @(posedge clk);
        #1;
        checkAll("reset_edge", 0, 0);
        @(negedge clk);
        reset = 1'b0;

        // LOAD 0xA5: q and q1 update, single done/busy cycle.
        applyStimulus(M_LOAD, 0, 8'hA5, -1, 1'b0);
        checkOutput("load_a5_q", 32'(q), 32'h0000_00A5);
        checkOutput("load_a5_q1", 32'(q1), 32'h0000_005A);

        // SAR by 3 from 0x81: sign fill, four busy cycles.
        applyStimulus(M_LOAD, 0, 8'h81, -1, 1'b0);
        applyStimulus(M_SAR, 3, 0, -1, 1'b0);
        checkOutput("sar3_q", 32'(q), 32'h0000_00F0);
        checkOutput("sar3_sout", 32'(sout), 32'h0);

        // ROL by 1 then SHL by 2 with sin held high.
        applyStimulus(M_LOAD, 0, 8'h81, -1, 1'b0);
        applyStimulus(M_ROL, 1, 0, -1, 1'b0);
        checkOutput("rol1_q", 32'(q), 32'h0000_0003);
        checkOutput("rol1_sout", 32'(sout), 32'h1);
        applyStimulus(M_SHL, 2, 0, 1, 1'b0);
        checkOutput("shl2_q", 32'(q), 32'h0000_000F);
        checkOutput("shl2_sout", 32'(sout), 32'h0);

        // SHR by 5 with sin low and CLR requests mid-shift and in DONE.
        applyStimulus(M_LOAD, 0, 8'hFF, -1, 1'b0);
        applyStimulus(M_SHR, 5, 0, 0, 1'b1);
        checkOutput("shr5_q", 32'(q), 32'h0000_0007);

        // Reset two steps into an SHL by 6, then LOAD on the first edge after.
        applyStimulus(M_LOAD, 0, 8'h55, -1, 1'b0);
        mode   = 3'(M_SHL);
        amount = AMT_W'(6);
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        for (int i = 1; i <= 2; i++) begin
            sinBit = int'($urandom_range(0, 1));
            sin = 1'(sinBit);
            stepModel(M_SHL, sinBit);
            @(negedge clk);
        end
        checkAll("abort_pre", 1, 0);
        #1;
        reset = 1'b1;
        #1;
        modelQ    = 0;
        modelSout = 0;
        checkAll("abort_rst", 0, 0);
        @(posedge clk);
        #1;
        checkAll("abort_hold", 0, 0);
        @(negedge clk);
        reset = 1'b0;
        applyStimulus(M_LOAD, 0, 8'h3C, -1, 1'b0);
        checkOutput("after_rst_q", 32'(q), 32'h0000_003C);

        // HOLD and a zero-length shift leave q and sout untouched.
        applyStimulus(M_SHL, 1, 0, 1, 1'b0);
        applyStimulus(M_LOAD, 0, 8'h3C, -1, 1'b0);
        applyStimulus(M_HOLD, int'($urandom_range(0, 7)), 8'hC3, -1, 1'b0);
        checkOutput("hold_q", 32'(q), 32'h0000_003C);
        applyStimulus(M_SHL, 0, 8'hC3, -1, 1'b0);
        checkOutput("shl0_q", 32'(q), 32'h0000_003C);

        // Randomized operation mix against the model.
        for (int n = 0; n < 40; n++) begin
            applyStimulus(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                          int'($urandom_range(0, 255)), -1, 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
